// File: rtl/reg_file_reader.sv
// Read-side sequencer for the matrix register file: walks a wrap-around address
// range and streams the words out over valid/ready through one output register.
module reg_file_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   REM_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   REM_ZERO = '0;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   rem;
  logic                  load;
  logic                  handshake;

  // The output register refills whenever it is empty or being drained this cycle.
  assign load      = (state == RUN) && (rem != REM_ZERO) && (!m_valid || m_ready);
  assign handshake = m_valid && m_ready;
  assign busy      = (state == RUN);
  assign r_addr    = ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      rem     <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != REM_ZERO) begin
              ptr   <= base_addr;
              rem   <= count;
              state <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          // rem is already zero when the last word is handed off, so no load collides here.
          if (handshake && m_last) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            done    <= 1'b1;
          end else if (load) begin
            m_data  <= r_data;
            m_valid <= 1'b1;
            m_last  <= (rem == REM_ONE);
            ptr     <= ptr + PTR_ONE;
            rem     <= rem - REM_ONE;
          end else if (handshake) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_reader.sv
// Scoreboard bench for reg_file_reader: scenarios push expected words into a queue,
// a negedge monitor pops and compares on every stream handshake.
module tb_reg_file_reader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] base_addr;
  logic [2:0] count;
  logic [1:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       busy;
  logic       done;

  logic [7:0] mem [4];
  logic [8:0] exp_q [$];
  int compared = 0;
  int mismatched = 0;

  reg_file_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .r_addr(r_addr), .r_data(r_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
  );

  assign r_data = mem[r_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushExp(input logic [7:0] data, input logic last);
    exp_q.push_back({last, data});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted word must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word at %0t", m_data, $time);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        checkOutput("m_data", {24'd0, m_data}, {24'd0, e[7:0]});
        checkOutput("m_last", {31'd0, m_last}, {31'd0, e[8]});
      end
    end
  end

  // Issues start in the current cycle (cycle 0), then checks cycles 1..n_cycles.
  task automatic applyStimulus(input logic [1:0] base, input logic [2:0] cnt,
                               input logic [15:0] low_mask, input int n_cycles,
                               input int done_cyc, input int busy_end, input int restart_cyc,
                               input int addr_n, input logic [15:0] addr_seq);
    logic       prev_valid, prev_ready, prev_last;
    logic [7:0] prev_data;
    start     = 1'b1;
    base_addr = base;
    count     = cnt;
    m_ready   = !low_mask[0];
    prev_valid = m_valid;
    prev_ready = m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    for (int c = 1; c <= n_cycles; c++) begin
      tick();
      start = (c == restart_cyc);
      if (c == restart_cyc) begin
        base_addr = 2'd1;
        count     = 3'd1;
      end
      m_ready = !low_mask[c];
      checkOutput("done", {31'd0, done}, {31'd0, (c == done_cyc)});
      checkOutput("busy", {31'd0, busy}, {31'd0, (c <= busy_end)});
      if (c <= addr_n)
        checkOutput("r_addr", {30'd0, r_addr}, {30'd0, addr_seq[2*(c-1) +: 2]});
      if (prev_valid && !prev_ready) begin
        checkOutput("hold_valid", {31'd0, m_valid}, 32'd1);
        checkOutput("hold_data", {24'd0, m_data}, {24'd0, prev_data});
        checkOutput("hold_last", {31'd0, m_last}, {31'd0, prev_last});
      end
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
    start = 1'b0;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; m_ready = 1'b1;
    tick(); tick();
    checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("rst_m_last", {31'd0, m_last}, 32'd0);
    checkOutput("rst_m_data", {24'd0, m_data}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_r_addr", {30'd0, r_addr}, 32'd0);
    reset = 1'b0;
    tick();

    // Full read, then a wrap command started in the done cycle.
    pushExp(8'h11, 1'b0); pushExp(8'h22, 1'b0); pushExp(8'h33, 1'b0); pushExp(8'h44, 1'b1);
    applyStimulus(2'd0, 3'd4, 16'h0000, 6, 6, 5, -1, 0, 16'h0000);
    pushExp(8'h44, 1'b0); pushExp(8'h11, 1'b0); pushExp(8'h22, 1'b0);
    pushExp(8'h33, 1'b0); pushExp(8'h44, 1'b0); pushExp(8'h11, 1'b1);
    applyStimulus(2'd3, 3'd6, 16'h0000, 8, 8, 7, -1, 6, 16'h0393);
    tick(); tick();

    // Backpressure in cycles 3-4.
    pushExp(8'h11, 1'b0); pushExp(8'h22, 1'b0); pushExp(8'h33, 1'b0); pushExp(8'h44, 1'b1);
    applyStimulus(2'd0, 3'd4, 16'h0018, 8, 8, 7, -1, 0, 16'h0000);
    tick();

    // Zero-length command.
    applyStimulus(2'd0, 3'd0, 16'h0000, 3, 1, 0, -1, 0, 16'h0000);
    tick();

    // Start pulsed mid-command is ignored.
    pushExp(8'h11, 1'b0); pushExp(8'h22, 1'b0); pushExp(8'h33, 1'b0); pushExp(8'h44, 1'b1);
    applyStimulus(2'd0, 3'd4, 16'h0000, 8, 6, 5, 2, 0, 16'h0000);
    tick();

    // Reset in cycle 3 of a 4-word read.
    pushExp(8'h11, 1'b0);
    start = 1'b1; base_addr = 2'd0; count = 3'd4; m_ready = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick(); m_ready = 1'b0; reset = 1'b1;
    tick(); reset = 1'b0;
    checkOutput("abort_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    tick(); m_ready = 1'b1;
    checkOutput("abort_done_next", {31'd0, done}, 32'd0);
    pushExp(8'h33, 1'b1);
    applyStimulus(2'd2, 3'd1, 16'h0000, 3, 3, 2, -1, 1, 16'h0002);
    tick(); tick();

    checkOutput("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reg_file_reader.md
# reg_file_reader

Read-side sequencer for the matrix register file in the QR decomposition datapath. On a start command it walks a contiguous, wrap-around range of register-file addresses and streams the stored words out over a valid/ready interface with a last marker. A single output register buffers the data, so it sustains one word per cycle under continuous ready and holds data stable under backpressure. It drives the register file's asynchronous read port (address out, data in) and does not write the register file.

## Interface
- DATA_WIDTH, 8, word width; equals the register file's DATA_WIDTH
- ADDR_WIDTH, 2, register-file address width; depth is 2**ADDR_WIDTH
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first address to read; sampled with start
- count  in  ADDR_WIDTH+1  number of words to stream (0..2**(ADDR_WIDTH+1)-1); sampled with start
- r_addr  out  ADDR_WIDTH  register-file read address; driven directly from the pointer register
- r_data  in  DATA_WIDTH  register-file read data, combinational from r_addr
- m_data  out  DATA_WIDTH  stream data
- m_valid  out  1  stream data valid
- m_ready  in  1  downstream accept
- m_last  out  1  qualifies the final word of the command; meaningful only with m_valid
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on command completion

## Operation
- States: IDLE, RUN. Registers: ptr (ADDR_WIDTH), rem (ADDR_WIDTH+1), m_data, m_valid, m_last, done.
- Reset: state=IDLE, ptr=0, rem=0, m_data=0, m_valid=0, m_last=0, done=0. busy=0, r_addr=0.
- IDLE with start=1 and count!=0: ptr<=base_addr, rem<=count, state<=RUN.
- IDLE with start=1 and count=0: no transfer; done<=1 for one cycle; state stays IDLE.
- start while in RUN: ignored. base_addr and count are not sampled.
- RUN: load = (rem!=0) && (!m_valid || m_ready).
  - On load: m_data<=r_data, m_valid<=1, m_last<=(rem==1), ptr<=ptr+1 (modulo 2**ADDR_WIDTH), rem<=rem-1.
  - Handshake (m_valid && m_ready) without load: m_valid<=0, m_last<=0.
  - Handshake with m_last=1: state<=IDLE, m_valid<=0, m_last<=0, done<=1 on the next cycle.
- Address wrap: after 2**ADDR_WIDTH-1 the pointer rolls to 0. A count larger than the depth re-reads entries in order.
- r_data is sampled in the load cycle. A register-file write to that address in the same cycle is not seen, because the file's write lands at the edge. Later writes to already-loaded entries do not affect buffered m_data.
- While m_valid=1 and m_ready=0: m_data, m_last and ptr are held stable.
- done is low in all cycles except the single completion cycle.
- busy = (state==RUN).

## Timing
- Cycle numbering: start is asserted in cycle 0.
  - Cycle 1: RUN, busy=1, r_addr=base_addr.
  - Cycle 2: first word valid.
- With m_ready held high, word k appears in cycle 2+k. The last word of an N-word command is in cycle N+1.
- done=1 and busy=0 in the cycle after the last handshake. A new start is accepted in that same cycle.
- Each cycle of m_ready=0 while m_valid=1 adds one cycle to completion.
- Reset during RUN takes effect at the next edge: IDLE, m_valid=0, and no done pulse for the aborted command.

## Test plan
- Setup for all scenarios: ADDR_WIDTH=2, file = {0:0x11, 1:0x22, 2:0x33, 3:0x44}.
- Full read, m_ready=1, start base=0 count=4 -> m_data 0x11/0x22/0x33/0x44 in cycles 2..5; m_last only with 0x44; done=1 in cycle 6 only; busy=1 in cycles 1..5.
- Wrap, start base=3 count=6 -> 0x44, 0x11, 0x22, 0x33, 0x44, 0x11; m_last on the sixth word; r_addr sequence 3, 0, 1, 2, 3, 0.
- Backpressure, base=0 count=4, m_ready=0 in cycles 3–4 -> 0x22 held stable in cycles 3–5; no dropped or duplicated word; done in cycle 8.
- count=0 -> done=1 in cycle 1 only; m_valid and busy stay 0.
- Reset in cycle 3 of a 4-word read -> cycle 4: m_valid=0, busy=0, done=0. A new start base=2 count=1 then yields 0x33 with m_last=1.
- start pulsed in cycle 2 with base=1 during a running command -> ignored; the stream is unchanged and only one done pulse occurs.
